// File: rtl/ddr3_inport_arb.sv
// Two-port round-robin arbiter in front of the ddr3_core request port.
// Tags requests with the source port and routes responses back by ID bit 15.
module ddr3_inport_arb #(
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [15:0]  inport0_wr_i,
   input  logic         inport0_rd_i,
   input  logic [31:0]  inport0_addr_i,
   input  logic [127:0] inport0_write_data_i,
   input  logic [14:0]  inport0_req_id_i,
   output logic         inport0_accept_o,
   output logic         inport0_ack_o,
   output logic         inport0_error_o,
   output logic [14:0]  inport0_resp_id_o,
   output logic [127:0] inport0_read_data_o,
   input  logic [15:0]  inport1_wr_i,
   input  logic         inport1_rd_i,
   input  logic [31:0]  inport1_addr_i,
   input  logic [127:0] inport1_write_data_i,
   input  logic [14:0]  inport1_req_id_i,
   output logic         inport1_accept_o,
   output logic         inport1_ack_o,
   output logic         inport1_error_o,
   output logic [14:0]  inport1_resp_id_o,
   output logic [127:0] inport1_read_data_o,
   output logic [15:0]  outport_wr_o,
   output logic         outport_rd_o,
   output logic [31:0]  outport_addr_o,
   output logic [127:0] outport_write_data_o,
   output logic [15:0]  outport_req_id_o,
   input  logic         outport_accept_i,
   input  logic         outport_ack_i,
   input  logic         outport_error_i,
   input  logic [15:0]  outport_resp_id_i,
   input  logic [127:0] outport_read_data_i
);

   typedef enum logic {
      ST_IDLE,
      ST_GRANT
   } state_t;

   localparam logic [3:0] LP_MAX = 4'(MAX_OUTSTANDING);

   state_t     r_state;
   state_t     w_state_nxt;
   logic       r_grant;
   logic       w_grant_nxt;
   logic       r_last;
   logic [3:0] r_cnt0;
   logic [3:0] r_cnt1;

   logic w_req0;
   logic w_req1;
   logic w_elig0;
   logic w_elig1;
   logic w_gnt_act;
   logic w_fwd;
   logic w_acc0;
   logic w_acc1;
   logic w_ack0;
   logic w_ack1;

   assign w_req0  = (|inport0_wr_i) | inport0_rd_i;
   assign w_req1  = (|inport1_wr_i) | inport1_rd_i;
   assign w_elig0 = w_req0 & (r_cnt0 < LP_MAX);
   assign w_elig1 = w_req1 & (r_cnt1 < LP_MAX);

   // Outputs are masked during reset even if the state register is still GRANT.
   assign w_gnt_act = (r_state == ST_GRANT) & ~rst_i;
   assign w_fwd     = w_gnt_act & outport_accept_i;
   assign w_acc0    = w_fwd & ~r_grant;
   assign w_acc1    = w_fwd & r_grant;

   assign w_ack0 = outport_ack_i & ~outport_resp_id_i[15] & ~rst_i;
   assign w_ack1 = outport_ack_i & outport_resp_id_i[15] & ~rst_i;

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      unique case (r_state)
         ST_IDLE: begin
            if (w_elig0 && w_elig1) begin
               w_grant_nxt = ~r_last;
               w_state_nxt = ST_GRANT;
            end else if (w_elig0) begin
               w_grant_nxt = 1'b0;
               w_state_nxt = ST_GRANT;
            end else if (w_elig1) begin
               w_grant_nxt = 1'b1;
               w_state_nxt = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (outport_accept_i) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_grant <= 1'b0;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         if (w_fwd) begin
            r_last <= r_grant;
         end
      end
   end

   // Accept and ack together cancel; an ack at zero is a spurious response.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_cnt0 <= '0;
         r_cnt1 <= '0;
      end else begin
         case ({w_acc0, w_ack0})
            2'b10:   r_cnt0 <= r_cnt0 + 4'd1;
            2'b01:   r_cnt0 <= (r_cnt0 != 4'd0) ? r_cnt0 - 4'd1 : r_cnt0;
            default: r_cnt0 <= r_cnt0;
         endcase
         case ({w_acc1, w_ack1})
            2'b10:   r_cnt1 <= r_cnt1 + 4'd1;
            2'b01:   r_cnt1 <= (r_cnt1 != 4'd0) ? r_cnt1 - 4'd1 : r_cnt1;
            default: r_cnt1 <= r_cnt1;
         endcase
      end
   end

   always_comb begin
      outport_wr_o         = '0;
      outport_rd_o         = 1'b0;
      outport_addr_o       = '0;
      outport_write_data_o = '0;
      outport_req_id_o     = '0;
      if (w_gnt_act) begin
         if (r_grant) begin
            outport_wr_o         = inport1_wr_i;
            outport_rd_o         = inport1_rd_i & ~(|inport1_wr_i);
            outport_addr_o       = inport1_addr_i;
            outport_write_data_o = inport1_write_data_i;
            outport_req_id_o     = {1'b1, inport1_req_id_i};
         end else begin
            outport_wr_o         = inport0_wr_i;
            outport_rd_o         = inport0_rd_i & ~(|inport0_wr_i);
            outport_addr_o       = inport0_addr_i;
            outport_write_data_o = inport0_write_data_i;
            outport_req_id_o     = {1'b0, inport0_req_id_i};
         end
      end
   end

   assign inport0_accept_o    = w_acc0;
   assign inport1_accept_o    = w_acc1;
   assign inport0_ack_o       = w_ack0;
   assign inport1_ack_o       = w_ack1;
   assign inport0_error_o     = outport_error_i & ~outport_resp_id_i[15] & ~rst_i;
   assign inport1_error_o     = outport_error_i & outport_resp_id_i[15] & ~rst_i;
   assign inport0_resp_id_o   = outport_resp_id_i[14:0];
   assign inport1_resp_id_o   = outport_resp_id_i[14:0];
   assign inport0_read_data_o = outport_read_data_i;
   assign inport1_read_data_o = outport_read_data_i;

endmodule

// File: tb/tb_ddr3_inport_arb.sv
// Scoreboard bench for ddr3_inport_arb: expected requests and responses are
// queued by the stimulus and popped by a negedge monitor.
module tb_ddr3_inport_arb;

   typedef struct packed {
      logic [15:0]  wr;
      logic         rd;
      logic [31:0]  addr;
      logic [127:0] data;
      logic [15:0]  id;
   } req_t;

   typedef struct packed {
      logic [14:0]  id;
      logic         err;
      logic [127:0] data;
   } rsp_t;

   localparam logic [127:0] D0 = 128'hffeeddccbbaa99887766554433221100;
   localparam logic [127:0] DA = 128'h0123456789abcdef0011223344556677;
   localparam logic [127:0] DB = 128'hcafef00ddeadbeef5a5aa5a51234abcd;
   localparam logic [127:0] DC = 128'h00000000ffffffff0000000011111111;
   localparam logic [127:0] R1 = 128'h13579bdf02468ace13579bdf02468ace;
   localparam logic [127:0] R2 = 128'hfedcba9876543210fedcba9876543210;

   logic         clk_i = 1'b0;
   logic         rst_i = 1'b1;
   logic [15:0]  wr_r [2];
   logic         rd_r [2];
   logic [31:0]  addr_r [2];
   logic [127:0] wd_r [2];
   logic [14:0]  id_r [2];
   logic         acc0, acc1, ack0, ack1, err0, err1;
   logic [14:0]  rid0, rid1;
   logic [127:0] rdat0, rdat1;
   logic [15:0]  outport_wr_o;
   logic         outport_rd_o;
   logic [31:0]  outport_addr_o;
   logic [127:0] outport_write_data_o;
   logic [15:0]  outport_req_id_o;
   logic         outport_accept_i = 1'b1;
   logic         outport_ack_i = 1'b0;
   logic         outport_error_i = 1'b0;
   logic [15:0]  outport_resp_id_i = '0;
   logic [127:0] outport_read_data_i = '0;

   int nchk = 0;
   int nerr = 0;
   req_t q_req[$];
   rsp_t q_rsp0[$];
   rsp_t q_rsp1[$];
   logic [127:0] mem [logic [31:0]];
   logic prev_acc = 1'b0;

   always #5 clk_i = ~clk_i;

   ddr3_inport_arb #(.MAX_OUTSTANDING(2)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .inport0_wr_i(wr_r[0]), .inport0_rd_i(rd_r[0]),
      .inport0_addr_i(addr_r[0]), .inport0_write_data_i(wd_r[0]),
      .inport0_req_id_i(id_r[0]), .inport0_accept_o(acc0),
      .inport0_ack_o(ack0), .inport0_error_o(err0),
      .inport0_resp_id_o(rid0), .inport0_read_data_o(rdat0),
      .inport1_wr_i(wr_r[1]), .inport1_rd_i(rd_r[1]),
      .inport1_addr_i(addr_r[1]), .inport1_write_data_i(wd_r[1]),
      .inport1_req_id_i(id_r[1]), .inport1_accept_o(acc1),
      .inport1_ack_o(ack1), .inport1_error_o(err1),
      .inport1_resp_id_o(rid1), .inport1_read_data_o(rdat1),
      .outport_wr_o(outport_wr_o), .outport_rd_o(outport_rd_o),
      .outport_addr_o(outport_addr_o),
      .outport_write_data_o(outport_write_data_o),
      .outport_req_id_o(outport_req_id_o),
      .outport_accept_i(outport_accept_i), .outport_ack_i(outport_ack_i),
      .outport_error_i(outport_error_i),
      .outport_resp_id_i(outport_resp_id_i),
      .outport_read_data_i(outport_read_data_i)
   );

   function automatic void chk(string n, logic [255:0] a, logic [255:0] e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endfunction

   function automatic void flag(string n);
      nchk++;
      nerr++;
      $display("FAIL %s: got event want none", n);
   endfunction

   function automatic void exp_req(logic [15:0] w, logic r, logic [31:0] a,
                                   logic [127:0] d, logic [15:0] id);
      req_t x;
      x = '{wr: w, rd: r, addr: a, data: d, id: id};
      q_req.push_back(x);
   endfunction

   function automatic void exp_rsp(int p, logic [14:0] id, logic e,
                                   logic [127:0] d);
      rsp_t x;
      x = '{id: id, err: e, data: d};
      if (p == 0) q_rsp0.push_back(x);
      else q_rsp1.push_back(x);
   endfunction

   function automatic logic acc_of(int p);
      return (p == 0) ? acc0 : acc1;
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(int p, logic [15:0] w, logic r, logic [31:0] a,
                          logic [127:0] d, logic [14:0] id);
      wr_r[p] = w; rd_r[p] = r; addr_r[p] = a; wd_r[p] = d; id_r[p] = id;
   endtask

   task automatic clr_req(int p);
      wr_r[p] = '0; rd_r[p] = 1'b0; addr_r[p] = '0; wd_r[p] = '0; id_r[p] = '0;
   endtask

   task automatic issue(int p, logic [15:0] w, logic r, logic [31:0] a,
                        logic [127:0] d, logic [14:0] id);
      bit got = 0;
      set_req(p, w, r, a, d, id);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk_i);
         if (acc_of(p)) begin
            got = 1;
            break;
         end
      end
      if (!got) flag($sformatf("accept_timeout_p%0d_id%0h", p, id));
      tick();
      clr_req(p);
   endtask

   task automatic respond(logic [15:0] rid, logic e, logic [127:0] d);
      outport_ack_i = 1'b1;
      outport_error_i = e;
      outport_resp_id_i = rid;
      outport_read_data_i = d;
      tick();
      outport_ack_i = 1'b0;
      outport_error_i = 1'b0;
      outport_read_data_i = '0;
   endtask

   always @(negedge clk_i) begin
      req_t g;
      rsp_t r;
      logic v;
      v = (outport_wr_o != 16'h0) || outport_rd_o;
      if (prev_acc) chk("idle_bubble", {outport_wr_o, outport_rd_o}, 0);
      if (v && outport_accept_i) begin
         g = '{wr: outport_wr_o, rd: outport_rd_o, addr: outport_addr_o,
               data: outport_write_data_o, id: outport_req_id_o};
         if (q_req.size() == 0) flag("unexpected_request");
         else chk("fwd_request", g, q_req.pop_front());
         if (outport_wr_o != 16'h0) mem[outport_addr_o] = outport_write_data_o;
      end
      prev_acc <= v && outport_accept_i;
      if (ack0) begin
         r = '{id: rid0, err: err0, data: rdat0};
         if (q_rsp0.size() == 0) flag("unexpected_ack_p0");
         else chk("rsp_p0", r, q_rsp0.pop_front());
      end else if (err0) flag("error_without_ack_p0");
      if (ack1) begin
         r = '{id: rid1, err: err1, data: rdat1};
         if (q_rsp1.size() == 0) flag("unexpected_ack_p1");
         else chk("rsp_p1", r, q_rsp1.pop_front());
      end else if (err1) flag("error_without_ack_p1");
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_req(0);
      clr_req(1);
      // reset state, with a response presented that must stay blocked
      set_req(0, 16'hFFFF, 1'b1, 32'h10, DA, 15'h7);
      outport_ack_i = 1'b1;
      outport_error_i = 1'b1;
      outport_resp_id_i = 16'h8000;
      outport_read_data_i = R1;
      tick();
      tick();
      @(negedge clk_i);
      chk("rst_wr", outport_wr_o, 0);
      chk("rst_rd", outport_rd_o, 0);
      chk("rst_addr", outport_addr_o, 0);
      chk("rst_wdata", outport_write_data_o, 0);
      chk("rst_reqid", outport_req_id_o, 0);
      chk("rst_acc", {acc0, acc1}, 0);
      chk("rst_ack", {ack0, ack1}, 0);
      chk("rst_err", {err0, err1}, 0);
      tick();
      clr_req(0);
      outport_ack_i = 1'b0;
      outport_error_i = 1'b0;
      outport_read_data_i = '0;
      rst_i = 1'b0;
      tick();

      // single-port write then read
      exp_req(16'hFFFF, 1'b0, 32'h0, D0, 16'h0011);
      issue(0, 16'hFFFF, 1'b0, 32'h0, D0, 15'h11);
      chk("cnt0_after_wr", dut.r_cnt0, 1);
      exp_rsp(0, 15'h11, 1'b0, '0);
      respond(16'h0011, 1'b0, '0);
      chk("cnt0_after_wr_ack", dut.r_cnt0, 0);
      exp_req(16'h0, 1'b1, 32'h0, '0, 16'h0012);
      issue(0, 16'h0, 1'b1, 32'h0, '0, 15'h12);
      exp_rsp(0, 15'h12, 1'b0, D0);
      respond(16'h0012, 1'b0, mem[32'h0]);
      // write and read together: write wins
      exp_req(16'h00FF, 1'b0, 32'h40, DC, 16'h8013);
      issue(1, 16'h00FF, 1'b1, 32'h40, DC, 15'h13);
      exp_rsp(1, 15'h13, 1'b0, '0);
      respond(16'h8013, 1'b0, '0);

      // simultaneous requests from reset: 0,1,0,1
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      exp_req(16'h000F, 1'b0, 32'h100, DA, 16'h0003);
      exp_req(16'h0, 1'b1, 32'h200, '0, 16'h8005);
      exp_req(16'h0, 1'b1, 32'h104, '0, 16'h0004);
      exp_req(16'hF000, 1'b0, 32'h204, DB, 16'h8006);
      fork
         begin
            issue(0, 16'h000F, 1'b0, 32'h100, DA, 15'h3);
            issue(0, 16'h0, 1'b1, 32'h104, '0, 15'h4);
         end
         begin
            issue(1, 16'h0, 1'b1, 32'h200, '0, 15'h5);
            issue(1, 16'hF000, 1'b0, 32'h204, DB, 15'h6);
         end
      join
      chk("sim_cnt", {dut.r_cnt0, dut.r_cnt1}, 8'h22);

      // interleaved responses with error routing
      exp_rsp(1, 15'h5, 1'b0, R1);
      respond(16'h8005, 1'b0, R1);
      exp_rsp(0, 15'h3, 1'b1, '0);
      respond(16'h0003, 1'b1, '0);
      exp_rsp(1, 15'h6, 1'b1, '0);
      respond(16'h8006, 1'b1, '0);
      exp_rsp(0, 15'h4, 1'b0, R2);
      respond(16'h0004, 1'b0, R2);
      chk("il_cnt", {dut.r_cnt0, dut.r_cnt1}, 8'h00);

      // outstanding limit of 2
      exp_req(16'h0, 1'b1, 32'h300, '0, 16'h0020);
      issue(0, 16'h0, 1'b1, 32'h300, '0, 15'h20);
      exp_req(16'h0, 1'b1, 32'h310, '0, 16'h0021);
      issue(0, 16'h0, 1'b1, 32'h310, '0, 15'h21);
      set_req(0, 16'h0, 1'b1, 32'h320, '0, 15'h22);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk_i);
         chk("limit_no_grant", {acc0, outport_rd_o}, 0);
      end
      chk("limit_cnt0", dut.r_cnt0, 2);
      tick();
      exp_req(16'h0, 1'b1, 32'h320, '0, 16'h0022);
      exp_rsp(0, 15'h20, 1'b0, R1);
      respond(16'h0020, 1'b0, R1);
      @(negedge clk_i);
      chk("limit_idle_after_ack", acc0, 0);
      @(negedge clk_i);
      chk("limit_grant_after_ack", acc0, 1);
      tick();
      clr_req(0);
      exp_rsp(0, 15'h21, 1'b0, '0);
      respond(16'h0021, 1'b0, '0);
      exp_rsp(0, 15'h22, 1'b0, '0);
      respond(16'h0022, 1'b0, '0);
      chk("limit_cnt0_drained", dut.r_cnt0, 0);

      // same-cycle accept and ack, then spurious ack
      exp_req(16'h0, 1'b1, 32'h400, '0, 16'h0030);
      issue(0, 16'h0, 1'b1, 32'h400, '0, 15'h30);
      exp_req(16'h0, 1'b1, 32'h410, '0, 16'h0031);
      set_req(0, 16'h0, 1'b1, 32'h410, '0, 15'h31);
      tick();
      exp_rsp(0, 15'h30, 1'b0, DC);
      outport_ack_i = 1'b1;
      outport_resp_id_i = 16'h0030;
      outport_read_data_i = DC;
      @(negedge clk_i);
      chk("same_cycle_acc", acc0, 1);
      tick();
      outport_ack_i = 1'b0;
      outport_read_data_i = '0;
      clr_req(0);
      chk("same_cycle_cnt0", dut.r_cnt0, 1);
      exp_rsp(0, 15'h31, 1'b0, '0);
      respond(16'h0031, 1'b0, '0);
      chk("cnt0_zero", dut.r_cnt0, 0);
      exp_rsp(0, 15'h77, 1'b0, DB);
      respond(16'h0077, 1'b0, DB);
      chk("spurious_cnt0", dut.r_cnt0, 0);

      // reset while port 1 is granted
      exp_req(16'h0, 1'b1, 32'h500, '0, 16'h0040);
      issue(0, 16'h0, 1'b1, 32'h500, '0, 15'h40);
      outport_accept_i = 1'b0;
      set_req(1, 16'h0001, 1'b0, 32'h510, DA, 15'h41);
      tick();
      @(negedge clk_i);
      chk("mid_grant_id", outport_req_id_o, 16'h8041);
      tick();
      rst_i = 1'b1;
      outport_ack_i = 1'b1;
      outport_error_i = 1'b1;
      outport_resp_id_i = 16'h8000;
      set_req(0, 16'h0, 1'b1, 32'h520, '0, 15'h42);
      @(negedge clk_i);
      chk("rst_mid_out", {outport_wr_o, outport_req_id_o}, 0);
      chk("rst_mid_ack", {acc1, ack1, err1}, 0);
      tick();
      rst_i = 1'b0;
      outport_ack_i = 1'b0;
      outport_error_i = 1'b0;
      outport_accept_i = 1'b1;
      @(negedge clk_i);
      chk("post_rst_out", {outport_wr_o, outport_rd_o, outport_req_id_o}, 0);
      chk("post_rst_cnt", {dut.r_cnt0, dut.r_cnt1}, 0);
      chk("post_rst_acc", {acc0, acc1}, 0);
      exp_req(16'h0, 1'b1, 32'h520, '0, 16'h0042);
      exp_req(16'h0001, 1'b0, 32'h510, DA, 16'h8041);
      fork
         issue(0, 16'h0, 1'b1, 32'h520, '0, 15'h42);
         issue(1, 16'h0001, 1'b0, 32'h510, DA, 15'h41);
      join
      tick();
      tick();
      chk("req_queue_empty", q_req.size(), 0);
      chk("rsp_queue_empty", q_rsp0.size() + q_rsp1.size(), 0);
      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/ddr3_inport_arb.md
# ddr3_inport_arb

Two-port round-robin arbiter that lets two requesters share the single 128-bit `inport` request interface of `ddr3_core`. The arbiter sits between the requesters and `ddr3_core`. It tags each forwarded request with the index of its source port and routes each `ack` back to that port by response ID. It also limits how many requests each port can have outstanding.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 4: maximum un-acked requests per port. Legal range is 1..15.

Ports (n = 0, 1):
- `clk_i` in 1: the single clock.
- `rst_i` in 1: reset, synchronous, active-high.
- `inport{n}_wr_i` in 16: write byte-enable mask. A nonzero value means a write request.
- `inport{n}_rd_i` in 1: read request.
- `inport{n}_addr_i` in 32: byte address.
- `inport{n}_write_data_i` in 128: write data.
- `inport{n}_req_id_i` in 15: requester transaction ID.
- `inport{n}_accept_o` out 1: request accepted this cycle.
- `inport{n}_ack_o` out 1: response valid.
- `inport{n}_error_o` out 1: response error.
- `inport{n}_resp_id_o` out 15: response ID.
- `inport{n}_read_data_o` out 128: read data.
- `outport_wr_o` out 16, `outport_rd_o` out 1, `outport_addr_o` out 32, `outport_write_data_o` out 128: request to `ddr3_core`.
- `outport_req_id_o` out 16: forwarded ID, equal to {port index, `req_id[14:0]`}.
- `outport_accept_i` in 1, `outport_ack_i` in 1, `outport_error_i` in 1, `outport_resp_id_i` in 16, `outport_read_data_i` in 128: signals from `ddr3_core`.

## Operation
- Request protocol on each port:
  - A port is requesting when `wr_i != 0` or `rd_i` is high.
  - The requester holds all request fields stable until it sees `accept_o`.
  - If `wr_i != 0` and `rd_i` are both high, the write wins and `outport_rd_o` is driven 0.
- Eligibility: port n is eligible when it is requesting and `cnt{n} < MAX_OUTSTANDING`.
- State machine, with states IDLE and GRANT:
  - **IDLE**: all `outport_*` request outputs are 0.
    - Exactly one port eligible: register `grant` = that port and move to GRANT.
    - Both ports eligible: `grant` = the port that is not `last`.
    - No port eligible: stay in IDLE.
  - **GRANT**: the granted port's fields are muxed to `outport_*`. `outport_req_id_o` = {`grant`, `req_id_i[14:0]`}.
    - `inport{grant}_accept_o` = `outport_accept_i`. The other port's `accept_o` is 0.
    - On `outport_accept_i`: set `last` <= `grant` and return to IDLE.
    - Otherwise stay in GRANT, even if the other port becomes eligible. There is no preemption.
- Outstanding counters `cnt0` and `cnt1`, 4 bits each:
  - Increment on accept to the port.
  - Decrement on ack to the port.
  - Accept and ack to the same port in the same cycle: counter unchanged.
  - Decrement when the counter is 0 (spurious ack): counter holds at 0 and the ack is still forwarded.
- Response routing (combinational):
  - `inport{n}_ack_o` = `outport_ack_i` & (`outport_resp_id_i[15]` == n).
  - `inport{n}_error_o` = `outport_error_i` & (`outport_resp_id_i[15]` == n).
  - `inport{n}_resp_id_o` = `outport_resp_id_i[14:0]`.
  - `inport{n}_read_data_o` = `outport_read_data_i`, broadcast to both ports; it is qualified by `ack`.
- Reset effects:
  - State goes to IDLE, `last` = 1 (so port 0 wins the first tie), and `cnt0` = `cnt1` = 0.
  - A grant in progress is dropped. The requester keeps holding its request and is re-arbitrated after reset.
  - Responses still in flight in `ddr3_core` after reset are out of scope.

## Timing
- Reset values (while `rst_i` is high, `ack_o`/`error_o` are forced 0):
  - All `outport_*` request outputs: 0.
  - All `accept_o`: 0.
  - All `ack_o` and `error_o`: 0.
  - State: IDLE.
- Request latency: a request presented in IDLE at cycle t appears on `outport_*` at cycle t+1.
- Accept: earliest `accept_o` is at t+1, the same cycle `outport_accept_i` is high.
- Throughput: the minimum spacing between forwarded requests is 2 cycles (one IDLE bubble after each accept).
- Response latency: 0 cycles, combinational from `outport_ack_i`.
- Eligibility timing: eligibility is sampled in IDLE using the registered counters. An ack arriving in the same IDLE cycle frees a slot only from the next cycle.
- GRANT has no timeout.

## Test plan
- **Single-port write then read:** port 0 writes 128'hffeeddccbbaa99887766554433221100 to addr 0 with mask 16'hFFFF, then reads addr 0. Required:
  - `outport_req_id_o[15]` = 0.
  - Port 0 ack returns the same data.
  - Port 1 sees no ack.
- **Simultaneous requests:** both ports hold requests starting from reset. Required:
  - Grant order is 0, 1, 0, 1 over four accepts.
  - Forwarded IDs are {0,id0} and {1,id1}.
  - Each accept is followed by exactly one IDLE cycle.
- **Outstanding limit:** `MAX_OUTSTANDING`=2, acks withheld, port 0 issues 3 requests. Required:
  - Two accepts occur.
  - The third request stays un-granted and `cnt0` = 2.
  - One ack to port 0 lets the third be granted in the following IDLE cycle.
- **Interleaved responses:** `ddr3_core` returns acks with `resp_id` 16'h8005 then 16'h0003. Required:
  - Port 1 gets `ack` with `resp_id` 15'h0005.
  - Port 0 then gets `ack` with `resp_id` 15'h0003.
  - `error_i` pulse routed only to the addressed port.
- **Same-cycle accept and ack** on port 0 with `cnt0` = 1: `cnt0` remains 1. A spurious ack when `cnt0` = 0 is forwarded and the counter stays 0.
- **Reset mid-GRANT:** port 1 is granted and `outport_accept_i` is held low; assert `rst_i` for one cycle. Required:
  - Next cycle, all outputs are 0 and `cnt` values are 0.
  - With both ports requesting after reset, port 0 is granted first.
